// File: rtl/jogo_memoria_param.sv
// jogo_memoria_param -- sequence-memory ("Genius") game controller.
//
// Round r asks the player to repeat sequence entries 0..r in order. The
// sequence lives in an external memory with a combinational read port; this
// block owns the FSM, the round/play counters, button edge detection and the
// per-play timeout.
//
// Optional feature: define MOSTRA_SEQUENCIA_EN to light entries 0..rodada on
// the LEDs (TEMPO_MOSTRA cycles lit, TEMPO_MOSTRA cycles blank each) before
// every round. Without it PREPARA/PROX_RODADA go straight to ESPERA.
//
// Ports
//   clock, reset        rising-edge clock, async active-high reset
//   iniciar             start/restart, honoured only in INICIAL and final states
//   botoes[N]           player buttons, active-high
//   mem_dado[N]         sequence word at mem_addr
//   mem_addr[ADDR_W]    sequence index being compared or displayed
//   leds[N]             last play / sequence display
//   pronto/acertou/errou/db_timeout   end-of-game flags
//   db_estado/db_rodada/db_jogada     debug view of state and counters

// One button lane: input register plus its delayed copy for edge detection.
module jogo_memoria_param_botao (
  input  logic clock,
  input  logic reset,
  input  logic botao,
  output logic reg_b,
  output logic reg_b_prev
);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_b      <= 1'b0;
      reg_b_prev <= 1'b0;
    end else begin
      reg_b      <= botao;
      reg_b_prev <= reg_b;
    end
  end
endmodule

module jogo_memoria_param #(
  parameter int N_BOTOES       = 4,
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CICLOS = 3000,
  parameter int TEMPO_MOSTRA   = 500
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic [N_BOTOES-1:0] mem_dado,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [N_BOTOES-1:0] leds,
  output logic                pronto,
  output logic                acertou,
  output logic                errou,
  output logic [3:0]          db_estado,
  output logic [ADDR_W-1:0]   db_rodada,
  output logic [ADDR_W-1:0]   db_jogada,
  output logic                db_timeout
);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    MOSTRA      = 4'h2,
    APAGA       = 4'h3,
    ESPERA      = 4'h4,
    REGISTRA    = 4'h5,
    COMPARA     = 4'h6,
    PROX_JOGADA = 4'h7,
    PROX_RODADA = 4'h8,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } estado_t;

  localparam int                TO_W   = $clog2(TIMEOUT_CICLOS);
  localparam logic [TO_W-1:0]   TO_MAX = TO_W'(TIMEOUT_CICLOS - 1);
  localparam logic [ADDR_W-1:0] ULTIMA = {ADDR_W{1'b1}};

  // Both counters terminate on "== limit-1", so a limit below 2 has no
  // representable terminal count.
  if (TIMEOUT_CICLOS < 2 || TEMPO_MOSTRA < 2) begin : g_param_invalido
    $error("jogo_memoria_param: TIMEOUT_CICLOS and TEMPO_MOSTRA must be >= 2");
  end

  estado_t             estado;
  logic [ADDR_W-1:0]   rodada, jogada;
  logic [N_BOTOES-1:0] jogada_reg, leds_q;
  logic [TO_W-1:0]     cnt_to;
  logic [N_BOTOES-1:0] reg_b, reg_b_prev;
  logic                tem_jogada;

  for (genvar i = 0; i < N_BOTOES; i++) begin : g_botao
    jogo_memoria_param_botao u_botao (
      .clock      (clock),
      .reset      (reset),
      .botao      (botoes[i]),
      .reg_b      (reg_b[i]),
      .reg_b_prev (reg_b_prev[i])
    );
  end

  // A play is the rising edge of "any button pressed"; adding buttons while
  // one is still held does not create a new play.
  assign tem_jogada = (|reg_b) & ~(|reg_b_prev);

`ifdef MOSTRA_SEQUENCIA_EN
  localparam int              MO_W   = $clog2(TEMPO_MOSTRA);
  localparam logic [MO_W-1:0] MO_MAX = MO_W'(TEMPO_MOSTRA - 1);
  logic [MO_W-1:0] cnt_mostra;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado     <= INICIAL;
      rodada     <= '0;
      jogada     <= '0;
      jogada_reg <= '0;
      leds_q     <= '0;
      cnt_to     <= '0;
      pronto     <= 1'b0;
      acertou    <= 1'b0;
      errou      <= 1'b0;
      db_timeout <= 1'b0;
`ifdef MOSTRA_SEQUENCIA_EN
      cnt_mostra <= '0;
`endif
    end else begin
      case (estado)
        INICIAL: if (iniciar) estado <= PREPARA;

        PREPARA: begin
          rodada <= '0;
          jogada <= '0;
          leds_q <= '0;
          cnt_to <= '0;
`ifdef MOSTRA_SEQUENCIA_EN
          cnt_mostra <= '0;
          estado     <= MOSTRA;
`else
          estado <= ESPERA;
`endif
        end

`ifdef MOSTRA_SEQUENCIA_EN
        MOSTRA: begin
          if (cnt_mostra == MO_MAX) begin
            cnt_mostra <= '0;
            estado     <= APAGA;
          end else begin
            cnt_mostra <= cnt_mostra + MO_W'(1);
          end
        end

        APAGA: begin
          if (cnt_mostra == MO_MAX) begin
            cnt_mostra <= '0;
            if (jogada == rodada) begin
              jogada <= '0;
              cnt_to <= '0;
              estado <= ESPERA;
            end else begin
              jogada <= jogada + ADDR_W'(1);
              estado <= MOSTRA;
            end
          end else begin
            cnt_mostra <= cnt_mostra + MO_W'(1);
          end
        end
`endif

        // A press on the last allowed cycle still counts as a play.
        ESPERA: begin
          if (tem_jogada) begin
            jogada_reg <= reg_b;
            estado     <= REGISTRA;
          end else if (cnt_to == TO_MAX) begin
            leds_q     <= '0;
            pronto     <= 1'b1;
            errou      <= 1'b1;
            db_timeout <= 1'b1;
            estado     <= FIM_TIMEOUT;
          end else begin
            cnt_to <= cnt_to + TO_W'(1);
          end
        end

        REGISTRA: begin
          leds_q <= jogada_reg;
          estado <= COMPARA;
        end

        // mem_dado is always one-hot, so a multi-button capture can never match.
        COMPARA: begin
          if (jogada_reg != mem_dado) begin
            leds_q <= '0;
            pronto <= 1'b1;
            errou  <= 1'b1;
            estado <= FIM_ERRO;
          end else if (jogada < rodada) begin
            estado <= PROX_JOGADA;
          end else if (rodada == ULTIMA) begin
            leds_q  <= '0;
            pronto  <= 1'b1;
            acertou <= 1'b1;
            estado  <= FIM_ACERTO;
          end else begin
            estado <= PROX_RODADA;
          end
        end

        PROX_JOGADA: begin
          jogada <= jogada + ADDR_W'(1);
          cnt_to <= '0;
          estado <= ESPERA;
        end

        PROX_RODADA: begin
          rodada <= rodada + ADDR_W'(1);
          jogada <= '0;
          cnt_to <= '0;
`ifdef MOSTRA_SEQUENCIA_EN
          cnt_mostra <= '0;
          estado     <= MOSTRA;
`else
          estado <= ESPERA;
`endif
        end

        // Flags drop together with the restart so they are high only in final states.
        FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
          if (iniciar) begin
            pronto     <= 1'b0;
            acertou    <= 1'b0;
            errou      <= 1'b0;
            db_timeout <= 1'b0;
            estado     <= PREPARA;
          end
        end

        default: estado <= INICIAL;
      endcase
    end
  end

  // Display states override the play shown on the LEDs; mem_dado follows the
  // registered index, so this stays a function of registered state.
  always_comb begin
    leds = leds_q;
`ifdef MOSTRA_SEQUENCIA_EN
    if (estado == MOSTRA)     leds = mem_dado;
    else if (estado == APAGA) leds = '0;
`endif
  end

  assign mem_addr  = jogada;
  assign db_estado = estado;
  assign db_rodada = rodada;
  assign db_jogada = jogada;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Self-checking bench for jogo_memoria_param (default parameters).
// Sequence memory model: entry k = 1 << (k mod 4).
module tb_jogo_memoria_param;
  localparam int N  = 4;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset, iniciar;
  logic [N-1:0]  botoes, mem_dado, leds;
  logic [AW-1:0] mem_addr, db_rodada, db_jogada;
  logic          pronto, acertou, errou, db_timeout;
  logic [3:0]    db_estado;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  always_comb mem_dado = 4'b0001 << mem_addr[1:0];

  jogo_memoria_param #(
    .N_BOTOES(N), .ADDR_W(AW), .TIMEOUT_CICLOS(3000), .TEMPO_MOSTRA(500)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes),
    .mem_dado(mem_dado), .mem_addr(mem_addr), .leds(leds),
    .pronto(pronto), .acertou(acertou), .errou(errou),
    .db_estado(db_estado), .db_rodada(db_rodada), .db_jogada(db_jogada),
    .db_timeout(db_timeout)
  );

  typedef struct {
    logic       restart;
    logic [3:0] press;
    logic [3:0] estado, rodada, jogada, leds;
    logic       pronto, errou;
  } vec_t;

  vec_t tbl[12];

  // {estado, rodada, jogada, mem_addr, leds, pronto, acertou, errou, timeout}
  function automatic logic [23:0] obs();
    return {db_estado, db_rodada, db_jogada, mem_addr, leds,
            pronto, acertou, errou, db_timeout};
  endfunction

  function automatic logic [23:0] exp_v(input logic [3:0] e, r, j, l,
                                        input logic p, a, er, t);
    return {e, r, j, j, l, p, a, er, t};
  endfunction

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_settle(input int bound);
    int n = 0;
    while (!(db_estado inside {4'h4, 4'hA, 4'hD, 4'hE}) && n < bound) begin
      tick();
      n++;
    end
    if (n >= bound) begin
      n_cmp++;
      n_err++;
      $display("FAIL settle: state %h after %0d cycles, expected ESPERA or final", db_estado, n);
    end
  endtask

  task automatic restart();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    wait_settle(20000);
  endtask

  task automatic press(input logic [3:0] v);
    botoes = v;
    repeat (10) tick();
    botoes = '0;
    repeat (10) tick();
    wait_settle(20000);
  endtask

  task automatic set_v(input int i, input logic rs, input logic [3:0] pr, e, r, j, l,
                       input logic p, er);
    tbl[i] = '{rs, pr, e, r, j, l, p, er};
  endtask

  // Watchdog: the run must always end on its own.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; iniciar = 1'b0; botoes = '0;
    tick(); tick();
    check("reset_state", obs(), '0);
    reset = 1'b0;
    tick(); tick();
    check("idle_no_start", obs(), '0);

    //      rs    press    est   rod   jog   leds     p     err
    set_v(0,  1'b1, 4'b0001, 4'h4, 4'd1, 4'd0, 4'b0001, 1'b0, 1'b0);
    set_v(1,  1'b0, 4'b0001, 4'h4, 4'd1, 4'd1, 4'b0001, 1'b0, 1'b0);
    set_v(2,  1'b0, 4'b0010, 4'h4, 4'd2, 4'd0, 4'b0010, 1'b0, 1'b0);
    set_v(3,  1'b0, 4'b0001, 4'h4, 4'd2, 4'd1, 4'b0001, 1'b0, 1'b0);
    set_v(4,  1'b0, 4'b0010, 4'h4, 4'd2, 4'd2, 4'b0010, 1'b0, 1'b0);
    set_v(5,  1'b0, 4'b0100, 4'h4, 4'd3, 4'd0, 4'b0100, 1'b0, 1'b0);
    set_v(6,  1'b1, 4'b0001, 4'h4, 4'd1, 4'd0, 4'b0001, 1'b0, 1'b0);
    set_v(7,  1'b0, 4'b0001, 4'h4, 4'd1, 4'd1, 4'b0001, 1'b0, 1'b0);
    set_v(8,  1'b0, 4'b0100, 4'hE, 4'd1, 4'd1, 4'b0000, 1'b1, 1'b1);
    set_v(9,  1'b1, 4'b0011, 4'hE, 4'd0, 4'd0, 4'b0000, 1'b1, 1'b1);
    set_v(10, 1'b1, 4'b1000, 4'hE, 4'd0, 4'd0, 4'b0000, 1'b1, 1'b1);
    set_v(11, 1'b0, 4'b0001, 4'hE, 4'd0, 4'd0, 4'b0000, 1'b1, 1'b1);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].restart) restart();
      press(tbl[i].press);
      check($sformatf("vec%0d", i), obs(),
            exp_v(tbl[i].estado, tbl[i].rodada, tbl[i].jogada, tbl[i].leds,
                  tbl[i].pronto, 1'b0, tbl[i].errou, 1'b0));
    end

    // Reset in the middle of ESPERA aborts at once, without waiting for an edge.
    restart();
    press(4'b0001);
    reset = 1'b1;
    #1;
    check("async_reset", obs(), '0);
    tick();
    check("reset_edge", obs(), '0);
    reset = 1'b0;
    tick();

    // A held button, even with another added, is a single play.
    restart();
    botoes = 4'b0001;
    repeat (30) tick();
    wait_settle(100);
    check("held_one_play", obs(), exp_v(4'h4, 4'd1, 4'd0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0));
    botoes = 4'b0011;
    repeat (10) tick();
    check("held_add_button", obs(), exp_v(4'h4, 4'd1, 4'd0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0));
    botoes = '0;
    repeat (10) tick();
    press(4'b0001);
    check("held_then_new", obs(), exp_v(4'h4, 4'd1, 4'd1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0));

    // Full 16-round correct game, then restart from FIM_ACERTO.
    restart();
    for (int r = 0; r < 16; r++) begin
      for (int j = 0; j <= r; j++) press(4'b0001 << (j % 4));
      if (r < 15) check($sformatf("round%0d", r), {20'b0, db_rodada}, {20'b0, 4'(r + 1)});
    end
    check("full_win", obs(), exp_v(4'hA, 4'd15, 4'd15, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0));
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    wait_settle(20000);
    check("win_restart", obs(), exp_v(4'h4, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0));

    // Timeout in round 2: ESPERA lasts exactly 3000 cycles.
    restart();
    press(4'b0001);
    press(4'b0001);
    botoes = 4'b0010;
    tick();
    botoes = '0;
    n = 0;
    while (!(db_estado == 4'h4 && db_rodada == 4'd2) && n < 10000) begin
      tick();
      n++;
    end
    n = 0;
    while (db_estado == 4'h4 && n < 4000) begin
      tick();
      n++;
    end
    check("timeout_cycles", 24'(n), 24'd3000);
    check("timeout_state", obs(), exp_v(4'hD, 4'd2, 4'd0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1));
    press(4'b0001);
    check("timeout_press_ignored", obs(), exp_v(4'hD, 4'd2, 4'd0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1));

`ifdef MOSTRA_SEQUENCIA_EN
    // Round 1 display: 0001 lit, blank, 0010 lit, blank, then ESPERA.
    restart();
    botoes = 4'b0001;
    tick();
    botoes = '0;
    n = 0;
    while (db_estado != 4'h2 && n < 50) begin
      tick();
      n++;
    end
    begin
      logic [3:0] ph_est [4] = '{4'h2, 4'h3, 4'h2, 4'h3};
      logic [3:0] ph_led [4] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000};
      for (int p = 0; p < 4; p++) begin
        n = 0;
        while (db_estado == ph_est[p] && leds == ph_led[p] && n < 2000) begin
          n++;
          tick();
        end
        check($sformatf("show_phase%0d", p), 24'(n), 24'd500);
      end
    end
    check("show_then_wait", {20'b0, db_estado}, 24'h4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
